// File: rtl/div_iter.sv
// Radix-2 restoring divider: 32 shift/subtract cycles, then sign fixup.
// Result packing is {quotient, remainder}, with a one-cycle valid pulse.
module div_iter #(
    parameter int unsigned SIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        div_cancel,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dvd_raw_q, dvd_raw_d;
    logic        sign_quo_q, sign_quo_d;
    logic        sign_rem_q, sign_rem_d;
    logic        tready_q, tready_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;

    logic        accept;
    logic        dvd_neg, dvs_neg;
    logic [31:0] dvd_mag, dvs_mag;
    logic [32:0] shifted, diff;
    logic [31:0] quo_fix, rem_fix;

    assign accept = s_axis_divisor_tvalid && s_axis_dividend_tvalid && !div_cancel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_raw_d  = dvd_raw_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        tvalid_d   = 1'b0;
        tdata_d    = tdata_q;

        dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[31];
        dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[31];
        dvd_mag = dvd_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
        dvs_mag = dvs_neg ? (32'd0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;

        // The remainder never reaches the divisor, so 33 bits cover the trial.
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};

        quo_fix = sign_quo_q ? (32'd0 - quo_q) : quo_q;
        rem_fix = sign_rem_q ? (32'd0 - rem_q) : rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = CALC;
                    cnt_d      = 5'd0;
                    rem_d      = 32'd0;
                    quo_d      = dvd_mag;
                    dvs_d      = dvs_mag;
                    dvd_raw_d  = s_axis_dividend_tdata;
                    sign_quo_d = dvd_neg ^ dvs_neg;
                    sign_rem_d = dvd_neg;
                end
            end
            CALC: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                // Divide-by-zero returns the raw dividend, bypassing sign fixup.
                if (dvs_q == 32'd0) tdata_d = {32'hFFFF_FFFF, dvd_raw_q};
                else                tdata_d = {quo_fix, rem_fix};
                tvalid_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (div_cancel && state_q != IDLE) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = tdata_q;
        end

        tready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            dvd_raw_q  <= 32'd0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            tready_q   <= 1'b1;
            tvalid_q   <= 1'b0;
            tdata_q    <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_raw_q  <= dvd_raw_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            tready_q   <= tready_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
        end
    end

    assign s_axis_divisor_tready  = tready_q;
    assign s_axis_dividend_tready = tready_q;
    assign m_axis_dout_tvalid     = tvalid_q;
    assign m_axis_dout_tdata      = tdata_q;

endmodule
